// File: rtl/alu_param_pipe.sv
// Parameterised ALU with split-operand capture FSM, wait timeout and a
// fixed-latency multiply path. All outputs are registered and qualified by OUT_VALID.
module alu_param_pipe #(
    parameter int DATA_WIDTH     = 8,
    parameter int CMD_WIDTH      = 4,
    parameter int TIMEOUT_CYCLES = 16,
    parameter int MUL_LATENCY    = 3
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic                      CE,
    input  logic                      MODE,
    input  logic                      CIN,
    input  logic [CMD_WIDTH-1:0]      CMD,
    input  logic [1:0]                INP_VALID,
    input  logic [DATA_WIDTH-1:0]     OPA,
    input  logic [DATA_WIDTH-1:0]     OPB,
    output logic [2*DATA_WIDTH-1:0]   RES,
    output logic                      COUT,
    output logic                      OFLOW,
    output logic                      G,
    output logic                      E,
    output logic                      L,
    output logic                      ERR,
    output logic                      OUT_VALID,
    output logic                      BUSY
);
    localparam int W   = DATA_WIDTH;
    localparam int SHW = $clog2(DATA_WIDTH);
    localparam int TW  = $clog2(TIMEOUT_CYCLES + 1);
    localparam int MW  = (MUL_LATENCY > 1) ? $clog2(MUL_LATENCY) : 1;
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [MW-1:0] ML_LAST = MW'(MUL_LATENCY - 1);

    typedef enum logic [2:0] {IDLE, WAIT_A, WAIT_B, EXEC, MUL} state_t;

    state_t          state_reg;
    logic [TW-1:0]   wait_cnt_reg;
    logic [MW-1:0]   mul_cnt_reg;
    logic [W-1:0]    opa_reg;
    logic [W-1:0]    opb_reg;
    logic [CMD_WIDTH-1:0] cmd_reg;
    logic            mode_reg;
    logic            cin_reg;

    logic [31:0]     cmd_i;
    logic            in_mul;
    logic            arrive;
    logic [W:0]      sum_w;
    logic [W-1:0]    logic_w;
    logic [2*W-1:0]  rot_dbl;
    logic [W:0]      mul_x;
    logic [W:0]      mul_y;
    logic [2*W-1:0]  mul_p;
    logic            add_op;
    logic            sub_op;
    logic [2*W-1:0]  alu_res;
    logic            alu_cout, alu_oflow, alu_g, alu_e, alu_l, alu_err;

    assign cmd_i  = 32'(cmd_reg);
    assign in_mul = MODE && ((32'(CMD) == 32'd9) || (32'(CMD) == 32'd10));
    assign arrive = (state_reg == WAIT_A) ? INP_VALID[0] : INP_VALID[1];

    // One shared multiplier; intermediates are W+1 bits, only the low 2W bits are kept.
    always_comb begin
        if (cmd_i == 32'd10) begin
            mul_x = {opa_reg, 1'b0};
            mul_y = {1'b0, opb_reg};
        end else begin
            mul_x = {1'b0, opa_reg} + (W+1)'(1);
            mul_y = {1'b0, opb_reg} + (W+1)'(1);
        end
        mul_p = {{(W-1){1'b0}}, mul_x} * {{(W-1){1'b0}}, mul_y};
    end

    always_comb begin
        alu_res   = '0;
        alu_cout  = 1'b0;
        alu_oflow = 1'b0;
        alu_g     = 1'b0;
        alu_e     = 1'b0;
        alu_l     = 1'b0;
        alu_err   = 1'b0;
        sum_w     = '0;
        logic_w   = '0;
        rot_dbl   = '0;
        add_op    = 1'b0;
        sub_op    = 1'b0;
        if (mode_reg) begin
            case (cmd_i)
                32'd0: begin sum_w = {1'b0, opa_reg} + {1'b0, opb_reg}; add_op = 1'b1; end
                32'd1: begin sum_w = {1'b0, opa_reg} - {1'b0, opb_reg}; sub_op = 1'b1; end
                32'd2: begin
                    sum_w  = {1'b0, opa_reg} + {1'b0, opb_reg} + {{W{1'b0}}, cin_reg};
                    add_op = 1'b1;
                end
                32'd3: begin
                    sum_w  = {1'b0, opa_reg} - {1'b0, opb_reg} - {{W{1'b0}}, cin_reg};
                    sub_op = 1'b1;
                end
                32'd4: begin sum_w = {1'b0, opa_reg} + (W+1)'(1); add_op = 1'b1; end
                32'd5: begin sum_w = {1'b0, opa_reg} - (W+1)'(1); sub_op = 1'b1; end
                32'd6: begin sum_w = {1'b0, opb_reg} + (W+1)'(1); add_op = 1'b1; end
                32'd7: begin sum_w = {1'b0, opb_reg} - (W+1)'(1); sub_op = 1'b1; end
                32'd8: begin
                    alu_g = (opa_reg > opb_reg);
                    alu_e = (opa_reg == opb_reg);
                    alu_l = (opa_reg < opb_reg);
                end
                32'd9, 32'd10: alu_res = mul_p;
                default: alu_err = 1'b1;
            endcase
            // Bit W of a W+1-bit difference is the borrow.
            if (add_op) begin
                alu_res  = {{(W-1){1'b0}}, sum_w};
                alu_cout = sum_w[W];
            end
            if (sub_op) begin
                alu_res   = {{W{1'b0}}, sum_w[W-1:0]};
                alu_oflow = sum_w[W];
            end
        end else begin
            case (cmd_i)
                32'd0:  logic_w = opa_reg & opb_reg;
                32'd1:  logic_w = ~(opa_reg & opb_reg);
                32'd2:  logic_w = opa_reg | opb_reg;
                32'd3:  logic_w = ~(opa_reg | opb_reg);
                32'd4:  logic_w = opa_reg ^ opb_reg;
                32'd5:  logic_w = ~(opa_reg ^ opb_reg);
                32'd6:  logic_w = ~opa_reg;
                32'd7:  logic_w = ~opb_reg;
                32'd8:  logic_w = opa_reg >> 1;
                32'd9:  logic_w = opa_reg << 1;
                32'd10: logic_w = opb_reg >> 1;
                32'd11: logic_w = opb_reg << 1;
                32'd12: begin
                    rot_dbl = {opa_reg, opa_reg} << opb_reg[SHW-1:0];
                    logic_w = rot_dbl[2*W-1:W];
                    alu_err = |opb_reg[W-1:SHW];
                end
                32'd13: begin
                    rot_dbl = {opa_reg, opa_reg} >> opb_reg[SHW-1:0];
                    logic_w = rot_dbl[W-1:0];
                    alu_err = |opb_reg[W-1:SHW];
                end
                default: alu_err = 1'b1;
            endcase
            alu_res = {{W{1'b0}}, logic_w};
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_reg    <= IDLE;
            wait_cnt_reg <= '0;
            mul_cnt_reg  <= '0;
            opa_reg      <= '0;
            opb_reg      <= '0;
            cmd_reg      <= '0;
            mode_reg     <= 1'b0;
            cin_reg      <= 1'b0;
            RES <= '0; COUT <= 1'b0; OFLOW <= 1'b0; G <= 1'b0; E <= 1'b0; L <= 1'b0;
            ERR <= 1'b0; OUT_VALID <= 1'b0; BUSY <= 1'b0;
        end else if (CE) begin
            RES <= '0; COUT <= 1'b0; OFLOW <= 1'b0; G <= 1'b0; E <= 1'b0; L <= 1'b0;
            ERR <= 1'b0; OUT_VALID <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (INP_VALID[0]) opa_reg <= OPA;
                    if (INP_VALID[1]) opb_reg <= OPB;
                    wait_cnt_reg <= '0;
                    case (INP_VALID)
                        2'b11: begin
                            cmd_reg     <= CMD;
                            mode_reg    <= MODE;
                            cin_reg     <= CIN;
                            mul_cnt_reg <= '0;
                            BUSY        <= in_mul;
                            state_reg   <= in_mul ? MUL : EXEC;
                        end
                        2'b01:   state_reg <= WAIT_B;
                        2'b10:   state_reg <= WAIT_A;
                        default: state_reg <= IDLE;
                    endcase
                end
                WAIT_A, WAIT_B: begin
                    if (arrive) begin
                        if (state_reg == WAIT_A) opa_reg <= OPA;
                        else                     opb_reg <= OPB;
                        cmd_reg      <= CMD;
                        mode_reg     <= MODE;
                        cin_reg      <= CIN;
                        wait_cnt_reg <= '0;
                        mul_cnt_reg  <= '0;
                        BUSY         <= in_mul;
                        state_reg    <= in_mul ? MUL : EXEC;
                    end else if (wait_cnt_reg == TO_LAST) begin
                        OUT_VALID    <= 1'b1;
                        ERR          <= 1'b1;
                        opa_reg      <= '0;
                        opb_reg      <= '0;
                        wait_cnt_reg <= '0;
                        state_reg    <= IDLE;
                    end else begin
                        wait_cnt_reg <= wait_cnt_reg + 1'b1;
                    end
                end
                EXEC: begin
                    RES <= alu_res; COUT <= alu_cout; OFLOW <= alu_oflow;
                    G <= alu_g; E <= alu_e; L <= alu_l; ERR <= alu_err;
                    OUT_VALID <= 1'b1;
                    state_reg <= IDLE;
                end
                MUL: begin
                    if (mul_cnt_reg == ML_LAST) begin
                        RES       <= alu_res;
                        ERR       <= alu_err;
                        OUT_VALID <= 1'b1;
                        BUSY      <= 1'b0;
                        state_reg <= IDLE;
                    end else begin
                        mul_cnt_reg <= mul_cnt_reg + 1'b1;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule
